// File: rtl/token_run_meter.sv
// token_run_meter: measures runs of '1' tokens; each length goes to a FWFT FIFO. Optional max_run via TOKEN_RUN_METER_MAX_TRACK_EN.
// Latency: length visible the cycle after the terminating 0 is sampled.
// Backpressure: FIFO_DEPTH runs buffered; a run arriving at a full FIFO with no pop is dropped and sets overflow.
module token_run_meter #(
    parameter int CNT_W      = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    output logic             len_valid,
    input  logic             len_ready,
    output logic [CNT_W-1:0] len_data,
    output logic [CNT_W-1:0] max_run,
    output logic             overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [AW:0] PTR_MSB = {1'b1, {AW{1'b0}}};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push_req;
    logic             push_ok;
    logic             drop;
    logic             sat;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = ((wr_ptr ^ rd_ptr) == PTR_MSB);
    assign len_valid = !empty;
    // Masked while empty so the stale slot never leaks out after reset.
    assign len_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign pop       = len_valid && len_ready;
    assign push_req  = !a && (cnt != '0);
    // A same-cycle pop frees a slot before the push is considered.
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign sat       = a && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (a) begin
                if (!sat) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (sat || drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr[AW-1:0]] <= cnt;
        end
    end

`ifdef TOKEN_RUN_METER_MAX_TRACK_EN
    logic [CNT_W-1:0] max_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
        end else if (push_ok && (cnt > max_q)) begin
            max_q <= cnt;
        end
    end

    assign max_run = max_q;
`else
    assign max_run = '0;
`endif

endmodule
